// File: rtl/branch_resolve_if.sv
// Redirect interface between the branch resolve unit, the ID stage and the fetch address selector.
// master = the resolve unit (consumes ID operands, drives redirect); slave = the ID/fetch side.
interface branch_resolve_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic              id_is_branch;
  logic              id_is_jump;
  logic [1:0]        id_cond;
  logic [ADDR_W-1:0] id_pc;
  logic [ADDR_W-1:0] id_offset;
  logic [ADDR_W-1:0] id_target;
  logic [DATA_W-1:0] id_rs_val;
  logic [DATA_W-1:0] id_rt_val;
  logic              fetch_ready;
  logic              redirect_select;
  logic [ADDR_W-1:0] redirect_address;
  logic              stall_id;
  logic              flush_if_id;
  logic [CNT_W-1:0]  branch_count;
  logic [CNT_W-1:0]  taken_count;

  modport master (
    input  id_valid, id_is_branch, id_is_jump, id_cond, id_pc, id_offset,
           id_target, id_rs_val, id_rt_val, fetch_ready,
    output redirect_select, redirect_address, stall_id, flush_if_id,
           branch_count, taken_count
  );

  modport slave (
    output id_valid, id_is_branch, id_is_jump, id_cond, id_pc, id_offset,
           id_target, id_rs_val, id_rt_val, fetch_ready,
    input  redirect_select, redirect_address, stall_id, flush_if_id,
           branch_count, taken_count
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves branches/jumps in a registered EX cycle, drives the fetch redirect, squashes
// wrong-path IF/ID contents and keeps saturating branch/taken statistics.
//
// state   | meaning
// IDLE    | waiting for a control-flow instruction
// RESOLVE | one EX cycle evaluating the captured branch/jump
// HOLD    | redirect pending, fetch not ready
// FLUSH   | wrong-path squash countdown
module branch_resolve_unit #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  branch_resolve_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_RESOLVE, S_HOLD, S_FLUSH} state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, off_q, tgt_q, addr_q, addr_d;
  logic [DATA_W-1:0] rs_q, rt_q;
  logic [1:0]        cond_q;
  logic              jump_q;
  logic [2:0]        flush_q;
  logic [CNT_W-1:0]  branch_q, taken_q;

  logic              capture, br_inc, tk_inc, flush_load;
  logic              cond_true, taken;
  logic [ADDR_W-1:0] target;

  always_comb begin
    case (cond_q)
      2'd0:    cond_true = (rs_q == rt_q);
      2'd1:    cond_true = (rs_q != rt_q);
      2'd2:    cond_true = ($signed(rs_q) <  $signed(rt_q));
      default: cond_true = ($signed(rs_q) >= $signed(rt_q));
    endcase
  end

  assign taken  = jump_q | cond_true;
  // Branch target wraps modulo 2^ADDR_W by plain truncation.
  assign target = jump_q ? tgt_q : (pc_q + ADDR_W'(1) + off_q);

  always_comb begin
    state_d             = state_q;
    addr_d              = addr_q;
    capture             = 1'b0;
    br_inc              = 1'b0;
    tk_inc              = 1'b0;
    flush_load          = 1'b0;
    bus.redirect_select = 1'b0;
    bus.stall_id        = 1'b0;
    bus.flush_if_id     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.id_valid && (bus.id_is_branch || bus.id_is_jump)) begin
          capture = 1'b1;
          state_d = S_RESOLVE;
        end
      end
      S_RESOLVE: begin
        br_inc = 1'b1;
        if (taken) begin
          addr_d = target;
          if (bus.fetch_ready) begin
            bus.redirect_select = 1'b1;
            tk_inc              = 1'b1;
            flush_load          = 1'b1;
            state_d             = S_FLUSH;
          end else begin
            state_d = S_HOLD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        bus.stall_id        = 1'b1;
        bus.redirect_select = 1'b1;
        if (bus.fetch_ready) begin
          tk_inc     = 1'b1;
          flush_load = 1'b1;
          state_d    = S_FLUSH;
        end
      end
      S_FLUSH: begin
        bus.flush_if_id = 1'b1;
        if (flush_q == 3'd0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address follows the fresh target in RESOLVE and otherwise holds the last redirect.
  assign bus.redirect_address = addr_d;
  assign bus.branch_count     = branch_q;
  assign bus.taken_count      = taken_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      off_q    <= '0;
      tgt_q    <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      cond_q   <= '0;
      jump_q   <= 1'b0;
      addr_q   <= '0;
      flush_q  <= '0;
      branch_q <= '0;
      taken_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      if (capture) begin
        pc_q   <= bus.id_pc;
        off_q  <= bus.id_offset;
        tgt_q  <= bus.id_target;
        rs_q   <= bus.id_rs_val;
        rt_q   <= bus.id_rt_val;
        cond_q <= bus.id_cond;
        jump_q <= bus.id_is_jump;
      end
      if (flush_load)
        flush_q <= FLUSH_LOAD;
      else if (state_q == S_FLUSH && flush_q != 3'd0)
        flush_q <= flush_q - 3'd1;
      if (br_inc && branch_q != '1) branch_q <= branch_q + CNT_W'(1);
      if (tk_inc && taken_q  != '1) taken_q  <= taken_q + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized bench for branch_resolve_unit against a per-instruction reference model;
// a second small-counter instance covers saturation.
module tb_branch_resolve_unit;
  localparam int FC      = 2;
  localparam int SAT_W   = 4;
  localparam int CNT_MAX = 65535;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_if #(.ADDR_W(8), .DATA_W(16), .CNT_W(16))    bus  ();
  branch_resolve_if #(.ADDR_W(8), .DATA_W(16), .CNT_W(SAT_W)) sbus ();

  branch_resolve_unit #(.ADDR_W(8), .DATA_W(16), .FLUSH_CYCLES(FC), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  branch_resolve_unit #(.ADDR_W(8), .DATA_W(16), .FLUSH_CYCLES(3), .CNT_W(SAT_W)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(sbus));

  int n_checks = 0;
  int n_fail   = 0;
  int m_br     = 0;
  int m_tk     = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_garbage();
    bus.id_valid     = 1'($urandom);
    bus.id_is_branch = 1'($urandom);
    bus.id_is_jump   = 1'($urandom);
    bus.id_cond      = 2'($urandom);
    bus.id_pc        = 8'($urandom);
    bus.id_offset    = 8'($urandom);
    bus.id_target    = 8'($urandom);
    bus.id_rs_val    = 16'($urandom);
    bus.id_rt_val    = 16'($urandom);
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic check_idle(input string tag);
    check_val({tag, "_sel"},   32'(bus.redirect_select), 32'd0);
    check_val({tag, "_stall"}, 32'(bus.stall_id),        32'd0);
    check_val({tag, "_flush"}, 32'(bus.flush_if_id),     32'd0);
    check_val({tag, "_brcnt"}, 32'(bus.branch_count),    32'(m_br));
    check_val({tag, "_tkcnt"}, 32'(bus.taken_count),     32'(m_tk));
  endtask

  // One instruction from IDLE to completion; hold_n = HOLD cycles with fetch_ready low.
  task automatic run_op(input bit br, input bit jmp, input logic [1:0] cond,
                        input logic [7:0] pc, input logic [7:0] off, input logic [7:0] tgt,
                        input logic [15:0] rs, input logic [15:0] rt, input int hold_n);
    bit   taken;
    int   sa, sb;
    logic [7:0] exp_t;
    sa = int'($signed(rs));
    sb = int'($signed(rt));
    case (cond)
      2'd0:    taken = (rs == rt);
      2'd1:    taken = (rs != rt);
      2'd2:    taken = (sa < sb);
      default: taken = (sa >= sb);
    endcase
    if (jmp) taken = 1'b1;
    exp_t = jmp ? tgt : 8'((int'(pc) + 1 + int'(off)) % 256);

    @(negedge clk);
    bus.id_valid = 1'b1; bus.id_is_branch = br; bus.id_is_jump = jmp; bus.id_cond = cond;
    bus.id_pc = pc; bus.id_offset = off; bus.id_target = tgt;
    bus.id_rs_val = rs; bus.id_rt_val = rt; bus.fetch_ready = 1'($urandom);
    #1 check_idle("idle");
    if (!br && !jmp) return;

    @(negedge clk);
    drive_garbage();
    bus.fetch_ready = (hold_n == 0);
    #1;
    check_val("res_sel",   32'(bus.redirect_select), 32'(taken && hold_n == 0));
    check_val("res_stall", 32'(bus.stall_id),        32'd0);
    check_val("res_flush", 32'(bus.flush_if_id),     32'd0);
    if (taken && hold_n == 0) check_val("res_addr", 32'(bus.redirect_address), 32'(exp_t));
    m_br = sat_inc(m_br);
    if (!taken) return;

    if (hold_n > 0) begin
      for (int i = 0; i <= hold_n; i++) begin
        @(negedge clk);
        drive_garbage();
        bus.fetch_ready = (i == hold_n);
        #1;
        check_val("hold_stall", 32'(bus.stall_id),         32'd1);
        check_val("hold_sel",   32'(bus.redirect_select),  32'd1);
        check_val("hold_addr",  32'(bus.redirect_address), 32'(exp_t));
        check_val("hold_flush", 32'(bus.flush_if_id),      32'd0);
      end
    end
    m_tk = sat_inc(m_tk);

    for (int i = 0; i < FC; i++) begin
      @(negedge clk);
      drive_garbage();
      bus.fetch_ready = 1'($urandom);
      #1;
      check_val("flush_on",    32'(bus.flush_if_id),     32'd1);
      check_val("flush_sel",   32'(bus.redirect_select), 32'd0);
      check_val("flush_stall", 32'(bus.stall_id),        32'd0);
      check_val("flush_brcnt", 32'(bus.branch_count),    32'(m_br));
      check_val("flush_tkcnt", 32'(bus.taken_count),     32'(m_tk));
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.id_valid = 1'b0;
    bus.fetch_ready = 1'($urandom);
    #1 check_idle("quiet");
  endtask

  initial begin
    logic [15:0] r1, r2;
    bus.id_valid = 0; bus.id_is_branch = 0; bus.id_is_jump = 0; bus.id_cond = 0;
    bus.id_pc = 0; bus.id_offset = 0; bus.id_target = 0;
    bus.id_rs_val = 0; bus.id_rt_val = 0; bus.fetch_ready = 0;
    sbus.id_valid = 0; sbus.id_is_branch = 0; sbus.id_is_jump = 0; sbus.id_cond = 0;
    sbus.id_pc = 0; sbus.id_offset = 0; sbus.id_target = 0;
    sbus.id_rs_val = 0; sbus.id_rt_val = 0; sbus.fetch_ready = 0;

    repeat (2) @(negedge clk);
    check_idle("reset");
    check_val("reset_addr", 32'(bus.redirect_address), 32'd0);
    rst_n = 1'b1;

    run_op(1, 0, 2'd0, 8'h10, 8'h05, 8'h00, 16'h1234, 16'h1234, 0);
    run_op(1, 0, 2'd1, 8'h20, 8'h07, 8'h00, 16'h0042, 16'h0042, 0);
    run_op(1, 0, 2'd2, 8'h03, 8'hFC, 8'h00, 16'h8000, 16'h0001, 0);
    run_op(1, 0, 2'd3, 8'h03, 8'hFC, 8'h00, 16'h8000, 16'h0001, 0);
    run_op(0, 1, 2'd1, 8'h40, 8'h00, 8'hA0, 16'h0001, 16'h0001, 2);
    run_op(1, 0, 2'd0, 8'hFF, 8'h01, 8'h00, 16'h0007, 16'h0007, 1);
    run_op(1, 1, 2'd1, 8'h50, 8'h10, 8'h77, 16'h0003, 16'h0003, 0);
    run_op(0, 0, 2'd0, 8'h60, 8'h01, 8'h00, 16'h0000, 16'h0000, 0);
    idle_cycle();

    for (int k = 0; k < 60; k++) begin
      r1 = 16'($urandom);
      r2 = ($urandom_range(0, 3) == 0) ? r1 : 16'($urandom);
      run_op(1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom),
             8'($urandom), r1, r2, int'($urandom_range(0, 3)));
    end
    idle_cycle();

    // Reset during HOLD drops the pending redirect and clears the counters.
    @(negedge clk);
    bus.id_valid = 1'b1; bus.id_is_jump = 1'b1; bus.id_is_branch = 1'b0;
    bus.id_target = 8'h55; bus.fetch_ready = 1'b0;
    @(negedge clk);
    drive_garbage(); bus.fetch_ready = 1'b0;
    @(negedge clk);
    drive_garbage(); bus.fetch_ready = 1'b0;
    #1 check_val("prerst_hold", 32'(bus.stall_id), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    m_br = 0;
    m_tk = 0;
    check_idle("midrst");
    check_val("midrst_addr", 32'(bus.redirect_address), 32'd0);
    @(negedge clk);
    bus.id_valid = 1'b0; bus.fetch_ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) idle_cycle();

    run_op(1, 0, 2'd0, 8'hFF, 8'h01, 8'h00, 16'h0000, 16'h0000, 0);
    idle_cycle();

    // Small-counter instance: a continuous taken-jump stream must pin both counters at max.
    @(negedge clk);
    sbus.id_valid = 1'b1; sbus.id_is_jump = 1'b1; sbus.id_target = 8'h33;
    sbus.fetch_ready = 1'b1;
    repeat (110) @(negedge clk);
    sbus.id_valid = 1'b0;
    repeat (6) @(negedge clk);
    check_val("sat_brcnt", 32'(sbus.branch_count), 32'((1 << SAT_W) - 1));
    check_val("sat_tkcnt", 32'(sbus.taken_count),  32'((1 << SAT_W) - 1));
    check_val("sat_addr",  32'(sbus.redirect_address), 32'h33);
    check_val("sat_sel",   32'(sbus.redirect_select),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
